// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline control logic: forwarding selects,
// hazard sequencer states and the ResultSrc encoding for loads.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one E-stage source operand. The newest producer (M)
// wins over W, and x0 is never forwarded.
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [4:0] Rs,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_t       Fwd
);

  always_comb begin
    Fwd = FWD_RF;
    if (Rs != 5'd0) begin
      if (RegWriteM && (RdM == Rs)) begin
        Fwd = FWD_M;
      end else if (RegWriteW && (RdW == Rs)) begin
        Fwd = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stalls, flushes, E-register enable,
// forwarding selects, mul/div freeze with timeout, and a stall-cycle counter.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MdStartE,
  input  logic             MdDone,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             EnE,
  output logic             MdBusy,
  output logic             MdErr,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int WW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'(MD_TIMEOUT - 1);

  hz_state_t        state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fwd_t fwdA, fwdB;
  logic lwStall;
  logic stallF, stallD, flushD, flushE, flushM, enE;

  fwd_sel u_fwd_a (
    .Rs(Rs1E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Fwd(fwdA)
  );

  fwd_sel u_fwd_b (
    .Rs(Rs2E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .Fwd(fwdB)
  );

  assign lwStall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken branch outranks a load-use stall because D holds a wrong-path instruction.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    stallF  = 1'b0;
    stallD  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    flushM  = 1'b0;
    enE     = 1'b1;
    case (state_q)
      RUN: begin
        if (PCSrcE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (lwStall) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end else if (MdStartE && !MdDone) begin
          stallF  = 1'b1;
          stallD  = 1'b1;
          enE     = 1'b0;
          flushM  = 1'b1;
          state_d = MD_WAIT;
          wait_d  = '0;
        end
      end
      MD_WAIT: begin
        stallF = 1'b1;
        stallD = 1'b1;
        enE    = 1'b0;
        flushM = 1'b1;
        if (MdDone) begin
          stallF  = 1'b0;
          stallD  = 1'b0;
          enE     = 1'b1;
          flushM  = 1'b0;
          state_d = RUN;
        end else if (wait_q == TO_LAST) begin
          flushE  = 1'b1;
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
    endcase
    cnt_d = (stallF && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced to their idle values while reset is held, without waiting for a clock.
  assign ForwardAE = reset ? fwdA   : FWD_RF;
  assign ForwardBE = reset ? fwdB   : FWD_RF;
  assign StallF    = reset && stallF;
  assign StallD    = reset && stallD;
  assign FlushD    = reset && flushD;
  assign FlushE    = reset && flushE;
  assign FlushM    = reset && flushM;
  assign EnE       = !reset || enE;
  assign MdBusy    = reset && (state_q == MD_WAIT);
  assign MdErr     = err_q;
  assign StallCnt  = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 6;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MdStartE, MdDone;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, FlushD, FlushE, FlushM, EnE, MdBusy, MdErr;
  logic [CNT_W-1:0] StallCnt;

  int total = 0;
  int bad   = 0;

  // Model state: whether the mul/div op is frozen in E, how many frozen cycles have elapsed.
  bit mFrozen;
  int mWaited;
  bit mErr;
  int mCnt;

  int eFwdA, eFwdB;
  bit eStallF, eStallD, eFlushD, eFlushE, eFlushM, eEnE, eBusy;
  bit nFrozen, nErr;
  int nWaited;
  int doneOdds;

  hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MdStartE(MdStartE), .MdDone(MdDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .EnE(EnE), .MdBusy(MdBusy), .MdErr(MdErr), .StallCnt(StallCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int refFwd(int rs);
    if (rs == 0) return 0;
    if (RegWriteM && int'(RdM) == rs) return 2;
    if (RegWriteW && int'(RdW) == rs) return 1;
    return 0;
  endfunction

  // Derives the expected outputs and the model's next state from the current inputs.
  task automatic computeExpected();
    bit loadUse;
    bit timeout;
    loadUse = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    {eStallF, eStallD, eFlushD, eFlushE, eFlushM, eBusy} = '0;
    eEnE    = 1'b1;
    eFwdA   = 0;
    eFwdB   = 0;
    nFrozen = mFrozen;
    nWaited = mWaited;
    nErr    = mErr;
    if (!reset) begin
      mFrozen = 0; mWaited = 0; mErr = 0; mCnt = 0;
      nFrozen = 0; nWaited = 0; nErr = 0;
      return;
    end
    eFwdA = refFwd(int'(Rs1E));
    eFwdB = refFwd(int'(Rs2E));
    if (mFrozen) begin
      eBusy   = 1'b1;
      timeout = (mWaited + 1 == MD_TIMEOUT);
      if (MdDone) begin
        nFrozen = 0;
      end else begin
        {eStallF, eStallD, eFlushM} = 3'b111;
        eEnE = 1'b0;
        if (timeout) begin
          eFlushE = 1'b1;
          nErr    = 1'b1;
          nFrozen = 0;
        end else begin
          nWaited = mWaited + 1;
        end
      end
    end else if (PCSrcE) begin
      eFlushD = 1'b1;
      eFlushE = 1'b1;
    end else if (loadUse) begin
      {eStallF, eStallD, eFlushE} = 3'b111;
    end else if (MdStartE && !MdDone) begin
      {eStallF, eStallD, eFlushM} = 3'b111;
      eEnE    = 1'b0;
      nFrozen = 1;
      nWaited = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("ForwardAE", 32'(ForwardAE), 32'(eFwdA));
    checkOutput("ForwardBE", 32'(ForwardBE), 32'(eFwdB));
    checkOutput("StallF",    32'(StallF),    32'(eStallF));
    checkOutput("StallD",    32'(StallD),    32'(eStallD));
    checkOutput("FlushD",    32'(FlushD),    32'(eFlushD));
    checkOutput("FlushE",    32'(FlushE),    32'(eFlushE));
    checkOutput("FlushM",    32'(FlushM),    32'(eFlushM));
    checkOutput("EnE",       32'(EnE),       32'(eEnE));
    checkOutput("MdBusy",    32'(MdBusy),    32'(eBusy));
    checkOutput("MdErr",     32'(MdErr),     32'(mErr));
    checkOutput("StallCnt",  32'(StallCnt),  32'(mCnt));
  endtask

  // Inputs are set right after a falling edge; check, clock once, return at the next falling edge.
  task automatic applyStimulus();
    #1;
    computeExpected();
    checkAll();
    @(posedge clk);
    if (reset) begin
      if (eStallF && mCnt < CNT_MAX) mCnt++;
      mFrozen = nFrozen;
      mWaited = nWaited;
      mErr    = nErr;
    end
    @(negedge clk);
  endtask

  task automatic setIdle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MdStartE, MdDone} = '0;
    ResultSrcE = 2'b00;
  endtask

  task automatic randomInputs();
    Rs1D = 5'($urandom_range(0, 3));
    Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3));
    Rs2E = 5'($urandom_range(0, 3));
    RdE  = 5'($urandom_range(0, 3));
    RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    RegWriteM  = 1'($urandom_range(0, 1));
    RegWriteW  = 1'($urandom_range(0, 1));
    ResultSrcE = 2'($urandom_range(0, 3));
    PCSrcE     = ($urandom_range(0, 4) == 0);
    MdStartE   = mFrozen ? 1'b1 : ($urandom_range(0, 4) == 0);
    MdDone     = ($urandom_range(0, doneOdds - 1) == 0);
  endtask

  initial begin
    mFrozen = 0; mWaited = 0; mErr = 0; mCnt = 0;
    doneOdds = 3;
    reset = 1'b0;
    setIdle();
    @(negedge clk);
    applyStimulus();
    reset = 1'b1;
    applyStimulus();

    // Forwarding: M beats W, x0 never forwarded.
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd5;
    applyStimulus();
    checkOutput("fwdM_prio", 32'(ForwardAE), 32'd2);
    Rs1E = 5'd0; RegWriteM = 1'b0;
    applyStimulus();
    checkOutput("fwdX0", 32'(ForwardAE), 32'd0);
    setIdle();

    // Load-use: one bubble, counter 0 -> 1.
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("lwCnt", 32'(StallCnt), 32'd1);

    // Load-use masked by a taken branch.
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("brCnt", 32'(StallCnt), 32'd1);

    // Mul/div completing on the 4th cycle.
    MdStartE = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus();
    MdDone = 1'b1;
    applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("mdBusyFall", 32'(MdBusy), 32'd0);

    // Mul/div timeout: entry cycle plus MD_TIMEOUT frozen cycles.
    MdStartE = 1'b1;
    for (int i = 0; i < MD_TIMEOUT + 1; i++) applyStimulus();
    setIdle();
    applyStimulus();
    checkOutput("mdTimeoutErr", 32'(MdErr), 32'd1);

    // Asynchronous reset while frozen.
    MdStartE = 1'b1;
    applyStimulus();
    applyStimulus();
    #2 reset = 1'b0;
    #1;
    computeExpected();
    checkAll();
    checkOutput("asyncBusy", 32'(MdBusy), 32'd0);
    @(negedge clk);
    applyStimulus();
    reset = 1'b1;
    setIdle();
    applyStimulus();

    // Random traffic, then a phase with rare MdDone so timeouts occur.
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      applyStimulus();
    end
    doneOdds = 12;
    for (int i = 0; i < 400; i++) begin
      randomInputs();
      applyStimulus();
    end
    setIdle();
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
